alu_issue_seq: RTL and testbench

ALU_ISSUE_SEQ -- requirements
Module: alu_issue_seq

---
 rtl/alu_issue_seq.sv | 207 ++++++++++++++++++++
 tb/tb_alu_issue_seq.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_seq.sv
`default_nettype none
// ============================================================================
//  Module   : alu_issue_seq
//  Purpose  : Buffers ALU requests in a 4-entry in-order FIFO and sequences
//             each request into one or two commands for an external ALU.
//             The ALU samples operands on the negedge during ISSUE and its
//             result is captured at the CAPT exit posedge. MUL and DIV take
//             two steps (high/quotient first, then low/remainder).
//             The result is presented with a valid/ready handshake.
//  Config   : `define ALU_DIVZERO_CHECK_EN traps DIV with a zero divisor
//             (divisor value field 0x0000 or 0x7FFF) without issuing ALU steps.
//  Ports    : clk, rst_n (async, active low)
//             in_valid/in_ready/in_op[2:0]/in_a[15:0]/in_b[15:0] : request
//             alu_a[15:0]/alu_b[15:0]/alu_cmd[2:0]                 : to ALU
//             alu_res[14:0]                                        : from ALU
//             out_valid/out_ready/out_hi[14:0]/out_lo[14:0]/out_err: result
//  Revision : 1.0 - initial release
// ============================================================================
module alu_issue_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_op,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [2:0]  alu_cmd,
    input  logic [14:0] alu_res,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [14:0] out_hi,
    output logic [14:0] out_lo,
    output logic        out_err
);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_ISSUE = 2'd1;
    localparam logic [1:0] c_S_CAPT  = 2'd2;
    localparam logic [1:0] c_S_DONE  = 2'd3;

    localparam logic [2:0] c_OP_ADD = 3'd0;
    localparam logic [2:0] c_OP_SUB = 3'd1;
    localparam logic [2:0] c_OP_AND = 3'd2;
    localparam logic [2:0] c_OP_MUL = 3'd3;
    localparam logic [2:0] c_OP_DIV = 3'd4;

    localparam logic [2:0] c_FULL = 3'd4;

    // FIFO storage: {op, a, b}
    logic [34:0] r_mem [0:3];
    logic [1:0]  r_wr_ptr;
    logic [1:0]  r_rd_ptr;
    logic [2:0]  r_count;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [2:0]  r_op;
    logic        r_step;     // 1 while working on the second step of MUL/DIV

    logic [15:0] r_alu_a;
    logic [15:0] r_alu_b;
    logic [2:0]  r_alu_cmd;
    logic [14:0] r_out_hi;
    logic [14:0] r_out_lo;
    logic        r_out_err;

    logic        w_push;
    logic        w_pop;
    logic [2:0]  w_head_op;
    logic [15:0] w_head_a;
    logic [15:0] w_head_b;
    logic        w_illegal;
    logic        w_divzero;
    logic        w_two_step;
    logic [2:0]  w_first_cmd;

    assign in_ready  = (r_count != c_FULL);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = (r_state == c_S_IDLE) && (r_count != 3'd0);
    assign w_head_op = r_mem[r_rd_ptr][34:32];
    assign w_head_a  = r_mem[r_rd_ptr][31:16];
    assign w_head_b  = r_mem[r_rd_ptr][15:0];
    assign w_illegal = (w_head_op > c_OP_DIV);
    assign w_two_step = (r_op == c_OP_MUL) || (r_op == c_OP_DIV);

`ifdef ALU_DIVZERO_CHECK_EN
    // The value field 0x7FFF is treated as a zero divisor as well.
    assign w_divzero = (w_head_op == c_OP_DIV) &&
                       ((w_head_b[15:1] == 15'h0000) || (w_head_b[15:1] == 15'h7FFF));
`else
    assign w_divzero = 1'b0;
`endif

    always_comb begin
        w_first_cmd = 3'd0;
        case (w_head_op)
            c_OP_ADD: w_first_cmd = 3'd0;
            c_OP_SUB: w_first_cmd = 3'd1;
            c_OP_AND: w_first_cmd = 3'd2;
            c_OP_MUL: w_first_cmd = 3'd3;
            c_OP_DIV: w_first_cmd = 3'd5;
            default:  w_first_cmd = 3'd0;
        endcase
    end

    // ---------------- FIFO ----------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_op, in_a, in_b};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= 2'd0;
            r_rd_ptr <= 2'd0;
            r_count  <= 3'd0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 2'd1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 2'd1;
            r_count <= r_count + {2'd0, w_push} - {2'd0, w_pop};
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= c_S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (w_pop) begin
                    // Trapped requests skip the ALU entirely.
                    w_state_nxt = (w_illegal || w_divzero) ? c_S_DONE : c_S_ISSUE;
                end
            end
            c_S_ISSUE: w_state_nxt = c_S_CAPT;
            c_S_CAPT:  w_state_nxt = (w_two_step && !r_step) ? c_S_ISSUE : c_S_DONE;
            c_S_DONE:  if (out_ready) w_state_nxt = c_S_IDLE;
            default:   w_state_nxt = c_S_IDLE;
        endcase
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op      <= 3'd0;
            r_step    <= 1'b0;
            r_alu_a   <= 16'd0;
            r_alu_b   <= 16'd0;
            r_alu_cmd <= 3'd0;
            r_out_hi  <= 15'd0;
            r_out_lo  <= 15'd0;
            r_out_err <= 1'b0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (w_pop) begin
                        r_op <= w_head_op;
                        if (w_illegal) begin
                            r_out_err <= 1'b1;
                            r_out_hi  <= 15'd0;
                            r_out_lo  <= 15'd0;
                        end else if (w_divzero) begin
                            r_out_err <= 1'b1;
                            r_out_hi  <= 15'h7FFF;
                            r_out_lo  <= 15'h7FFF;
                        end else begin
                            r_alu_a   <= w_head_a;
                            r_alu_b   <= w_head_b;
                            r_alu_cmd <= w_first_cmd;
                            r_step    <= 1'b0;
                            r_out_err <= 1'b0;
                        end
                    end
                end
                c_S_CAPT: begin
                    if (w_two_step && !r_step) begin
                        // Second command of each pair is the first plus one.
                        r_out_hi  <= alu_res;
                        r_alu_cmd <= r_alu_cmd + 3'd1;
                        r_step    <= 1'b1;
                    end else begin
                        r_out_lo <= alu_res;
                        if (!w_two_step) r_out_hi <= 15'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_cmd   = r_alu_cmd;
    assign out_hi    = r_out_hi;
    assign out_lo    = r_out_lo;
    assign out_err   = r_out_err;
    assign out_valid = (r_state == c_S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_issue_seq
//  Purpose  : Self-checking bench for alu_issue_seq. Contains a behavioural
//             ALU driving alu_res and a request-level result model used as a
//             scoreboard for directed, back-pressure, random and reset tests.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_issue_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_op = 3'd0;
    logic [15:0] in_a = 16'd0;
    logic [15:0] in_b = 16'd0;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [2:0]  alu_cmd;
    logic [14:0] alu_res = 15'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [14:0] out_hi;
    logic [14:0] out_lo;
    logic        out_err;

    int total = 0;
    int bad   = 0;

    alu_issue_seq dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cmd(alu_cmd), .alu_res(alu_res),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_hi(out_hi), .out_lo(out_lo), .out_err(out_err)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: samples operands/command on the negedge.
    int unsigned       m_av, m_bv;
    longint unsigned   m_p;
    always @(negedge clk) begin
        m_av = 32'(alu_a[15:1]);
        m_bv = 32'(alu_b[15:1]);
        m_p  = 64'(m_av) * 64'(m_bv);
        case (alu_cmd)
            3'd0: alu_res = 15'(m_av + m_bv);
            3'd1: alu_res = 15'(m_av - m_bv);
            3'd2: alu_res = 15'(m_av & m_bv);
            3'd3: alu_res = 15'(m_p >> 15);
            3'd4: alu_res = 15'(m_p);
            3'd5: alu_res = (m_bv == 0) ? 15'h7FFF : 15'(m_av / m_bv);
            3'd6: alu_res = (m_bv == 0) ? 15'(m_av) : 15'(m_av % m_bv);
            default: alu_res = 15'd0;
        endcase
    end

    // ---------------- reference model ----------------
    function automatic bit trapped(input logic [2:0] op, input logic [15:0] b);
        bit en;
`ifdef ALU_DIVZERO_CHECK_EN
        en = 1'b1;
`else
        en = 1'b0;
`endif
        return en && (op == 3'd4) && ((b[15:1] == 15'h0000) || (b[15:1] == 15'h7FFF));
    endfunction

    // Returns {err, hi, lo}
    function automatic logic [30:0] ref_res(input logic [2:0] op, input logic [15:0] a,
                                            input logic [15:0] b);
        longint unsigned av, bv, p;
        av = 64'(a[15:1]);
        bv = 64'(b[15:1]);
        p  = av * bv;
        case (op)
            3'd0: return {1'b0, 15'd0, 15'(av + bv)};
            3'd1: return {1'b0, 15'd0, 15'(av - bv)};
            3'd2: return {1'b0, 15'd0, 15'(av & bv)};
            3'd3: return {1'b0, p[29:15], p[14:0]};
            3'd4: begin
                if (trapped(op, b)) return {1'b1, 15'h7FFF, 15'h7FFF};
                if (bv == 0)        return {1'b0, 15'h7FFF, av[14:0]};
                return {1'b0, 15'(av / bv), 15'(av % bv)};
            end
            default: return {1'b1, 15'd0, 15'd0};
        endcase
    endfunction

    // ALU cycles (ISSUE + CAPT) spent on a request after it is popped.
    function automatic int alu_cycles(input logic [2:0] op, input logic [15:0] b);
        if (op > 3'd4 || trapped(op, b)) return 0;
        if (op == 3'd3 || op == 3'd4)    return 4;
        return 2;
    endfunction

    function automatic logic [2:0] step_cmd(input logic [2:0] op, input bit second);
        case (op)
            3'd0: return 3'd0;
            3'd1: return 3'd1;
            3'd2: return 3'd2;
            3'd3: return second ? 3'd4 : 3'd3;
            default: return second ? 3'd6 : 3'd5;
        endcase
    endfunction

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One request into an idle DUT; checks commands, latency, result, hold, release.
    task automatic run_single(input string tag, input logic [2:0] op, input logic [15:0] a,
                              input logic [15:0] b);
        logic [30:0] e;
        logic [30:0] held;
        logic [2:0]  prev_cmd, cmd1, cmd3, e1;
        int          steps, cyc;
        e        = ref_res(op, a, b);
        steps    = alu_cycles(op, b);
        prev_cmd = alu_cmd;
        e1       = (steps == 0) ? prev_cmd : step_cmd(op, 1'b0);
        out_ready = 1'b0;
        in_op = op; in_a = a; in_b = b; in_valid = 1'b1;
        tick();                       // accept edge
        in_valid = 1'b0;
        cyc = 0; cmd1 = 3'd0; cmd3 = 3'd0;
        while (!out_valid && cyc < 12) begin
            tick();
            cyc++;
            if (cyc == 1) cmd1 = alu_cmd;
            if (cyc == 3) cmd3 = alu_cmd;
        end
        if (cyc == 1 && out_valid) cmd1 = alu_cmd;
        // first edge after accept pops; out_valid follows after the ALU cycles
        chk({tag, " latency"}, cyc, 1 + steps);
        chk({tag, " cmd1"}, cmd1, e1);
        if (steps == 4) chk({tag, " cmd2"}, cmd3, step_cmd(op, 1'b1));
        chk({tag, " err"}, out_err, e[30]);
        chk({tag, " hi"},  out_hi,  e[29:15]);
        chk({tag, " lo"},  out_lo,  e[14:0]);
        held = {out_err, out_hi, out_lo};
        tick(); tick();
        chk({tag, " hold valid"}, out_valid, 1);
        chk({tag, " hold data"}, {out_err, out_hi, out_lo}, held);
        out_ready = 1'b1;
        tick();
        chk({tag, " release"}, out_valid, 0);
        out_ready = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    logic [30:0] sb[$];
    logic [30:0] prev_out;
    bit          prev_stall;
    int          acc, seen, guard;

    initial begin
        // reset state
        #1;
        chk("rst out_valid", out_valid, 0);
        chk("rst alu_cmd", alu_cmd, 0);
        chk("rst alu_a", alu_a, 0);
        chk("rst out_data", {out_err, out_hi, out_lo}, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("rst in_ready", in_ready, 1);

        // directed single requests
        run_single("add",     3'd0, 16'h000A, 16'h0006);
        run_single("sub",     3'd1, 16'h0010, 16'h0004);
        run_single("and",     3'd2, 16'h00FE, 16'h0038);
        run_single("mul",     3'd3, 16'h0008, 16'h000C);
        run_single("mulbig",  3'd3, 16'hFFFE, 16'hFFFE);
        run_single("div",     3'd4, 16'h000E, 16'h0004);
        run_single("div0",    3'd4, 16'h000E, 16'h0000);
        run_single("div7fff", 3'd4, 16'h1234, 16'hFFFF);
        run_single("ill7",    3'd7, 16'h1111, 16'h2222);
        run_single("addaft",  3'd0, 16'h0002, 16'h0002);
        run_single("ill5",    3'd5, 16'hFFFF, 16'hFFFF);

        // back-pressure: six back-to-back ADDs with the output stalled
        out_ready = 1'b0;
        acc = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_op = 3'd0;
            in_a  = 16'(i * 4 + 2);
            in_b  = 16'h0006;
            if (in_ready) begin
                acc++;
                sb.push_back(ref_res(in_op, in_a, in_b));
            end
            tick();
        end
        in_valid = 1'b0;
        chk("bp accepted", acc, 5);
        chk("bp in_ready", in_ready, 0);
        out_ready = 1'b1;
        guard = 0;
        while (sb.size() > 0 && guard < 60) begin
            if (out_valid) chk("bp result", {out_err, out_hi, out_lo}, sb.pop_front());
            tick();
            guard++;
        end
        chk("bp drained", sb.size(), 0);

        // random traffic against the scoreboard
        prev_stall = 1'b0;
        prev_out   = '0;
        for (int c = 0; c < 500; c++) begin
            in_valid  = ($urandom_range(0, 9) < 6);
            in_op     = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7))
                                                    : 3'($urandom_range(0, 4));
            in_a      = 16'($urandom);
            in_b      = ($urandom_range(0, 5) == 0) ? {15'h0, 1'($urandom)} : 16'($urandom);
            out_ready = ($urandom_range(0, 1) == 1);
            if (prev_stall) begin
                chk("rnd hold valid", out_valid, 1);
                chk("rnd hold data", {out_err, out_hi, out_lo}, prev_out);
            end
            if (out_valid && out_ready) begin
                chk("rnd expected pending", (sb.size() != 0), 1);
                if (sb.size() != 0) chk("rnd result", {out_err, out_hi, out_lo}, sb.pop_front());
            end
            if (in_valid && in_ready) sb.push_back(ref_res(in_op, in_a, in_b));
            prev_stall = out_valid && !out_ready;
            prev_out   = {out_err, out_hi, out_lo};
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        guard = 0;
        while (sb.size() > 0 && guard < 300) begin
            if (out_valid) chk("drain result", {out_err, out_hi, out_lo}, sb.pop_front());
            tick();
            guard++;
        end
        chk("drain empty", sb.size(), 0);
        tick(); tick();
        chk("no extra output", out_valid, 0);

        // reset in the middle of a MUL with two ADDs queued
        out_ready = 1'b0;
        in_op = 3'd3; in_a = 16'hFFFE; in_b = 16'hFFFE; in_valid = 1'b1;
        tick();
        in_op = 3'd0; in_a = 16'h0004; in_b = 16'h0004;
        tick();
        tick();
        in_valid = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid rst out_valid", out_valid, 0);
        chk("mid rst in_ready", in_ready, 1);
        chk("mid rst alu_cmd", alu_cmd, 0);
        chk("mid rst out_hi", out_hi, 0);
        tick(); tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (out_valid) seen++;
        end
        chk("post rst no output", seen, 0);
        chk("post rst in_ready", in_ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
